// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-side bus between the pipeline/instruction memory and fetch_pc_ctrl.
// The master is the pipeline side (stall/redirect producer, fetch consumer);
// the slave is the PC controller itself.
interface fetch_pc_ctrl_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic        imem_nop;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        misalign_err;
  logic        addr_wrap;
  logic [31:0] fetch_count;

  modport master (
    output stall, redirect_valid, redirect_target,
    input  imem_addr, imem_en, imem_nop, if_pc, if_valid,
    input  misalign_err, addr_wrap, fetch_count
  );

  modport slave (
    input  stall, redirect_valid, redirect_target,
    output imem_addr, imem_en, imem_nop, if_pc, if_valid,
    output misalign_err, addr_wrap, fetch_count
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Program-counter / fetch controller in front of a 1-cycle-latency
// instruction memory: boot cycle, stalls, redirects with bubble countdown,
// address wrap, and tracking of which PC the memory is currently presenting.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS    = 2048,
  parameter int unsigned FLUSH_BUBBLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  fetch_pc_ctrl_if.slave  bus
);

  localparam logic [32:0] ADDR_SPACE = 33'(IMEM_WORDS) << 2;
  localparam logic [31:0] PC_MASK    = 32'(ADDR_SPACE - 33'd1) & ~32'h3;
  localparam logic [2:0]  CNT_RELOAD = (FLUSH_BUBBLES == 0) ? 3'd0
                                                            : 3'(FLUSH_BUBBLES - 1);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic [31:0] pc, pc_nxt;
  logic        misalign_nxt, wrap_nxt;
  logic [32:0] pc_inc;

  // Memory controls are combinational so a redirect or stall takes effect
  // in the same cycle it is raised; the address only moves on edges.
  assign bus.imem_addr = pc;
  assign bus.imem_nop  = (state == BOOT) | (state == FLUSH) | bus.redirect_valid;
  assign bus.imem_en   = (state == RUN) & ~bus.stall & ~bus.redirect_valid;
  assign pc_inc        = {1'b0, pc} + 33'd4;

  // Next-state, next-PC and pulse decode; redirect beats stall beats advance.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_nxt    = state;
    cnt_nxt      = cnt;
    pc_nxt       = pc;
    misalign_nxt = 1'b0;
    wrap_nxt     = 1'b0;
    case (state)
      BOOT: state_nxt = RUN;
      RUN, FLUSH: begin
        if (bus.redirect_valid) begin
          pc_nxt       = bus.redirect_target & PC_MASK;
          misalign_nxt = |bus.redirect_target[1:0];
          wrap_nxt     = {1'b0, bus.redirect_target} >= ADDR_SPACE;
          cnt_nxt      = CNT_RELOAD;
          state_nxt    = (FLUSH_BUBBLES == 0) ? RUN : FLUSH;
        end else if (state == FLUSH) begin
          if (cnt == 3'd0) state_nxt = RUN;
          else             cnt_nxt   = cnt - 3'd1;
        end else if (bus.imem_en) begin
          pc_nxt   = pc_inc[31:0] & PC_MASK;
          wrap_nxt = pc_inc >= ADDR_SPACE;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  // State, PC, bubble counter and the registered error/wrap pulses.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state            <= BOOT;
      cnt              <= 3'd0;
      pc               <= RESET_PC;
      bus.misalign_err <= 1'b0;
      bus.addr_wrap    <= 1'b0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      pc               <= pc_nxt;
      bus.misalign_err <= misalign_nxt;
      bus.addr_wrap    <= wrap_nxt;
    end
  end

  // Fetch tracking: record the PC the memory will present next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.if_pc       <= RESET_PC;
      bus.if_valid    <= 1'b0;
      bus.fetch_count <= 32'd0;
    end else if (bus.imem_en) begin
      bus.if_pc       <= pc;
      bus.if_valid    <= 1'b1;
      bus.fetch_count <= bus.fetch_count + 32'd1;
    end else if (bus.imem_nop) begin
      bus.if_valid    <= 1'b0;
    end
  end

endmodule
